hamming_secded_dec_pipe: RTL and testbench

Parametrised, pipelined extended-Hamming (SECDED) decoder for the ECC datapath. It accepts codewords of width 2^M on a valid/ready stream and returns the corrected data word two cycles later with correction/detection flags and the error bit position. It keeps saturating counters of corrected and detected errors. It generalises the combinational 16/11 decoder to any M from 3 to 6, adds backpressure and a detect-only mode, and sits between the memory read port and the consumer.

---
 rtl/hamming_secded_dec_pipe.sv | 182 ++++++++++++++++++
 tb/tb_hamming_secded_dec_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_dec_pipe.sv
// -----------------------------------------------------------------------------
// hamming_secded_dec_pipe
//
// Two-stage pipelined extended-Hamming (SECDED) decoder on a valid/ready
// stream. Codeword width N = 2^M, data width K = N - M - 1.
//
// Codeword layout: bit 0 is overall even parity, bits 2^i are Hamming parity
// bits, data fills the remaining positions in ascending order.
//
// Stage 1 registers the syndrome, the overall parity error and the codeword.
// Stage 2 registers the classified result: corrected data, flags, position.
//
// Ports:
//   i_Clk, i_Rst_n      clock, asynchronous active-low reset
//   i_Valid, o_Ready    input handshake
//   i_CodeWord [N]      received codeword
//   i_CorrEn            1 = correct single errors, 0 = detect only
//   o_Valid, i_OutReady output handshake
//   o_DecodWord [K]     decoded data word
//   o_ErrorC            single error corrected
//   o_ErrorD            error detected, not corrected
//   o_ErrPos [M]        syndrome (flipped bit position), 0 when clean
//   i_CntClr            synchronous clear of both counters
//   o_CntC, o_CntD      saturating corrected / detected beat counters
// -----------------------------------------------------------------------------
module hamming_secded_dec_pipe #(
    parameter int unsigned M     = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic [(2**M)-1:0]     i_CodeWord,
    input  logic                  i_CorrEn,
    output logic                  o_Valid,
    input  logic                  i_OutReady,
    output logic [(2**M)-M-2:0]   o_DecodWord,
    output logic                  o_ErrorC,
    output logic                  o_ErrorD,
    output logic [M-1:0]          o_ErrPos,
    input  logic                  i_CntClr,
    output logic [CNT_W-1:0]      o_CntC,
    output logic [CNT_W-1:0]      o_CntD
);

    localparam int unsigned N = 2 ** M;
    localparam int unsigned K = N - M - 1;

    // Pipeline control
    logic         r_v1;
    logic         r_v2;
    logic         w_ld1;
    logic         w_ld2;
    logic         w_xfer_out;

    // Stage 1 state
    logic [N-1:0] r_cw1;
    logic         r_corr1;
    logic [M-1:0] r_syn1;
    logic         r_g1;

    // Stage 2 state
    logic [K-1:0] r_data2;
    logic         r_errc2;
    logic         r_errd2;
    logic [M-1:0] r_pos2;

    // Counters
    logic [CNT_W-1:0] r_cntc;
    logic [CNT_W-1:0] r_cntd;

    // Combinational
    logic [M-1:0] w_syn;
    logic         w_g;
    logic [N-1:0] w_fix;
    logic [K-1:0] w_data;
    logic         w_errc;
    logic         w_errd;

    assign w_ld2      = !r_v2 || i_OutReady;
    assign w_ld1      = !r_v1 || w_ld2;
    assign w_xfer_out = r_v2 && i_OutReady;

    assign o_Ready     = w_ld1;
    assign o_Valid     = r_v2;
    assign o_DecodWord = r_data2;
    assign o_ErrorC    = r_errc2;
    assign o_ErrorD    = r_errd2;
    assign o_ErrPos    = r_pos2;
    assign o_CntC      = r_cntc;
    assign o_CntD      = r_cntd;

    // Syndrome: every set bit at position p contributes p itself, which covers
    // exactly the parity groups whose index bit is set in p.
    always_comb begin
        w_syn = '0;
        for (int p = 1; p < N; p++) begin
            if (i_CodeWord[p]) begin
                w_syn = w_syn ^ M'(p);
            end
        end
    end

    assign w_g = ^i_CodeWord;

    // Stage 1
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_v1    <= 1'b0;
            r_cw1   <= '0;
            r_corr1 <= 1'b0;
            r_syn1  <= '0;
            r_g1    <= 1'b0;
        end else if (w_ld1) begin
            r_v1 <= i_Valid;
            if (i_Valid) begin
                r_cw1   <= i_CodeWord;
                r_corr1 <= i_CorrEn;
                r_syn1  <= w_syn;
                r_g1    <= w_g;
            end
        end
    end

    // Single-error flip; a syndrome of 0 flips the overall parity bit, which
    // never reaches the data field.
    assign w_fix = r_cw1 ^ ((r_g1 && r_corr1) ? (N'(1) << r_syn1) : '0);

    // Gather data bits from the non-power-of-two positions. Shifting in from
    // the top means the lowest position ends up at data bit 0.
    always_comb begin
        w_data = '0;
        for (int p = 3; p < N; p++) begin
            if ((p & (p - 1)) != 0) begin
                w_data = {w_fix[p], w_data[K-1:1]};
            end
        end
    end

    assign w_errc = r_g1 && r_corr1;
    assign w_errd = (r_g1 && !r_corr1) || (!r_g1 && (|r_syn1));

    // Stage 2
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_v2    <= 1'b0;
            r_data2 <= '0;
            r_errc2 <= 1'b0;
            r_errd2 <= 1'b0;
            r_pos2  <= '0;
        end else if (w_ld2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_data2 <= w_data;
                r_errc2 <= w_errc;
                r_errd2 <= w_errd;
                // A clean word has S = 0, so the syndrome is the position as is.
                r_pos2  <= r_syn1;
            end
        end
    end

    // Saturating counters; clear takes priority over a same-cycle increment.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_cntc <= '0;
            r_cntd <= '0;
        end else if (i_CntClr) begin
            r_cntc <= '0;
            r_cntd <= '0;
        end else begin
            if (w_xfer_out && r_errc2 && !(&r_cntc)) begin
                r_cntc <= r_cntc + 1'b1;
            end
            if (w_xfer_out && r_errd2 && !(&r_cntd)) begin
                r_cntd <= r_cntd + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// -----------------------------------------------------------------------------
// tb_hamming_secded_dec_pipe
//
// Bench for the M=4 SECDED decoder. A vector table of codewords with expected
// decode results drives the main instance; expectations are queued on input
// acceptance and compared when the output transfers. A second instance with
// 2-bit counters exercises counter saturation and clear priority.
// -----------------------------------------------------------------------------
module tb_hamming_secded_dec_pipe;

    typedef struct {
        logic [15:0] cw;
        logic        corr;
        logic [10:0] data;
        logic        c;
        logic        d;
        logic [3:0]  pos;
    } vec_t;

    typedef struct {
        logic [10:0] data;
        logic        c;
        logic        d;
        logic [3:0]  pos;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Main instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_cw = '0;
    logic        in_corr = 1'b1;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [10:0] out_data;
    logic        out_c;
    logic        out_d;
    logic [3:0]  out_pos;
    logic        cnt_clr = 1'b0;
    logic [15:0] cnt_c;
    logic [15:0] cnt_d;

    // Saturation instance
    logic        in2_valid = 1'b0;
    logic        in2_ready;
    logic [15:0] in2_cw = 16'h0020;
    logic        out2_valid;
    logic [10:0] out2_data;
    logic        out2_c;
    logic        out2_d;
    logic [3:0]  out2_pos;
    logic        cnt2_clr = 1'b0;
    logic [1:0]  cnt2_c;
    logic [1:0]  cnt2_d;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t tbl[11];

    always #5 clk = ~clk;

    hamming_secded_dec_pipe #(.M(4), .CNT_W(16)) u_dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Valid     (in_valid),
        .o_Ready     (in_ready),
        .i_CodeWord  (in_cw),
        .i_CorrEn    (in_corr),
        .o_Valid     (out_valid),
        .i_OutReady  (out_ready),
        .o_DecodWord (out_data),
        .o_ErrorC    (out_c),
        .o_ErrorD    (out_d),
        .o_ErrPos    (out_pos),
        .i_CntClr    (cnt_clr),
        .o_CntC      (cnt_c),
        .o_CntD      (cnt_d)
    );

    hamming_secded_dec_pipe #(.M(4), .CNT_W(2)) u_dut_sat (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Valid     (in2_valid),
        .o_Ready     (in2_ready),
        .i_CodeWord  (in2_cw),
        .i_CorrEn    (1'b1),
        .o_Valid     (out2_valid),
        .i_OutReady  (1'b1),
        .o_DecodWord (out2_data),
        .o_ErrorC    (out2_c),
        .o_ErrorD    (out2_d),
        .o_ErrPos    (out2_pos),
        .i_CntClr    (cnt2_clr),
        .o_CntC      (cnt2_c),
        .o_CntD      (cnt2_d)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of input drive; called at posedge+1, returns at next posedge+1.
    task automatic step_drive(input vec_t v, input logic vld, output logic acc);
        exp_t e;
        in_valid = vld;
        in_cw    = v.cw;
        in_corr  = v.corr;
        @(negedge clk);
        acc = vld && in_ready;
        if (acc) begin
            e.data = v.data;
            e.c    = v.c;
            e.d    = v.d;
            e.pos  = v.pos;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input vec_t v);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            step_drive(v, 1'b1, acc);
        end
        if (!acc) check("send_accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("sb_drain", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL sb_unexpected: got beat %0h, required no beat", out_data);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_data", 32'(out_data), 32'(mon_e.data));
                check("sb_errc", 32'(out_c), 32'(mon_e.c));
                check("sb_errd", 32'(out_d), 32'(mon_e.d));
                check("sb_pos", 32'(out_pos), 32'(mon_e.pos));
            end
        end
    end

    initial begin
        logic        acc;
        int          idx;
        logic [17:0] snap;

        //            cw        corr  data     c     d     pos
        tbl[0]  = '{16'h0000, 1'b1, 11'h000, 1'b0, 1'b0, 4'h0};
        tbl[1]  = '{16'hFFFF, 1'b1, 11'h7FF, 1'b0, 1'b0, 4'h0};
        tbl[2]  = '{16'h0020, 1'b1, 11'h000, 1'b1, 1'b0, 4'h5};
        tbl[3]  = '{16'hFFFE, 1'b1, 11'h7FF, 1'b1, 1'b0, 4'h0};
        tbl[4]  = '{16'h0021, 1'b1, 11'h002, 1'b0, 1'b1, 4'h5};
        tbl[5]  = '{16'h0020, 1'b0, 11'h002, 1'b0, 1'b1, 4'h5};
        tbl[6]  = '{16'h000F, 1'b1, 11'h001, 1'b0, 1'b0, 4'h0};
        tbl[7]  = '{16'h100F, 1'b1, 11'h001, 1'b1, 1'b0, 4'hC};
        tbl[8]  = '{16'h100F, 1'b0, 11'h081, 1'b0, 1'b1, 4'hC};
        tbl[9]  = '{16'h0003, 1'b1, 11'h000, 1'b0, 1'b1, 4'h1};
        tbl[10] = '{16'h7FFF, 1'b1, 11'h7FF, 1'b1, 1'b0, 4'hF};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_ready", 32'(in_ready), 1);
        check("rst_data", 32'(out_data), 0);
        check("rst_flags", 32'({out_c, out_d, out_pos}), 0);
        check("rst_cnt", 32'({cnt_c, cnt_d}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: two edges from presentation to o_Valid
        step_drive(tbl[0], 1'b1, acc);
        check("lat_accept0", 32'(acc), 1);
        check("lat_valid_early", 32'(out_valid), 0);
        step_drive(tbl[1], 1'b1, acc);
        check("lat_valid0", 32'(out_valid), 1);
        check("lat_data0", 32'(out_data), 32'h000);
        step_drive(tbl[0], 1'b0, acc);
        check("lat_valid1", 32'(out_valid), 1);
        check("lat_data1", 32'(out_data), 32'h7FF);
        drain();
        check("lat_cnt", 32'({cnt_c, cnt_d}), 0);

        // Vector table
        for (int i = 0; i < 11; i++) begin
            send(tbl[i]);
        end
        drain();
        check("tbl_cntc", 32'(cnt_c), 4);
        check("tbl_cntd", 32'(cnt_d), 4);

        // Backpressure: output stalled while four words are offered
        out_ready = 1'b0;
        idx = 0;
        snap = '0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            step_drive(tbl[idx], 1'b1, acc);
            if (acc) idx++;
            if (cyc == 1) begin
                snap = {out_valid, out_data, out_c, out_d, out_pos};
            end else if (cyc > 1) begin
                check("bp_hold", 32'({out_valid, out_data, out_c, out_d, out_pos}), 32'(snap));
            end
        end
        check("bp_accepted", 32'(idx), 2);
        check("bp_ready_low", 32'(in_ready), 0);
        check("bp_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && idx < 4; i++) begin
            step_drive(tbl[idx], 1'b1, acc);
            if (acc) idx++;
        end
        check("bp_all_sent", 32'(idx), 4);
        drain();
        check("bp_cntc", 32'(cnt_c), 6);
        check("bp_cntd", 32'(cnt_d), 4);

        // Saturating counters on the CNT_W=2 instance
        in2_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        in2_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("sat_cntc", 32'(cnt2_c), 3);
        check("sat_cntd", 32'(cnt2_d), 0);
        in2_valid = 1'b1;
        @(posedge clk);
        #1;
        in2_valid = 1'b0;
        @(posedge clk);
        #1;
        check("clr_beat_valid", 32'(out2_valid), 1);
        check("clr_beat_errc", 32'(out2_c), 1);
        cnt2_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt2_clr = 1'b0;
        check("clr_wins", 32'(cnt2_c), 0);
        @(posedge clk);
        #1;
        check("clr_hold", 32'(cnt2_c), 0);

        // Asynchronous reset mid-stream
        step_drive(tbl[0], 1'b1, acc);
        step_drive(tbl[0], 1'b1, acc);
        in_valid = 1'b1;
        check("mid_valid_pre", 32'(out_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_ready", 32'(in_ready), 1);
        check("mid_rst_cnt", 32'({cnt_c, cnt_d}), 0);
        check("mid_rst_data", 32'({out_data, out_c, out_d, out_pos}), 0);
        sb_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("post_rst_valid", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
